// File: rtl/ppu_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : ppu_out_packer
// Purpose  : Packs PPU output bytes into 32-bit little-endian words and issues
//            addressed word writes to the GLB through a small word FIFO.
// Options  : PACKER_PERF_CNT_EN enables the write-stall performance counter.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_out_packer #(
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_bytes,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic [3:0]        wr_strb,
   output logic              busy,
   output logic              done,
   output logic [31:0]       stall_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PACK  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WORD_W-1:0] pack_word;
   logic [WORD_W-1:0] push_data;
   logic [3:0]        push_strb;
   logic [1:0]        lane_idx;
   logic [LEN_W-1:0]  bytes_left;
   logic [ADDR_W-1:0] word_addr;
   logic              job_start;
   logic              accept;
   logic              last_byte;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W-1:0]  count_nxt;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;

   logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
   logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
   logic [3:0]        mem_strb [FIFO_DEPTH];

   // Write side is simply the FIFO head; it cannot change until popped.
   assign wr_valid = (fifo_count != '0);
   assign wr_addr  = mem_addr[rd_ptr];
   assign wr_data  = mem_data[rd_ptr];
   assign wr_strb  = mem_strb[rd_ptr];

   // Handshakes, word assembly and next-state decode.
   always_comb begin
      job_start = (state == IDLE) && start;
      accept    = in_valid && in_ready;
      last_byte = (bytes_left == LEN_W'(1));
      push      = accept && ((lane_idx == 2'd3) || last_byte);
      pop       = wr_valid && wr_ready;
      count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
      push_data = pack_word;
      push_data[{lane_idx, 3'b000} +: 8] = in_data;
      // Lanes up to and including the current one are valid.
      push_strb = 4'hF >> (2'd3 - lane_idx);
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (num_bytes == '0) ? DONE : PACK;
         PACK:    if (accept && last_byte) state_nxt = DRAIN;
         DRAIN:   if (count_nxt == '0) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control FSM with registered handshake and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt == PACK) && (count_nxt < DEPTH_C);
         busy     <= (state_nxt != IDLE);
         done     <= (state_nxt == DONE);
      end
   end

   // Lane packing, remaining byte count and word address generation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pack_word  <= '0;
         lane_idx   <= 2'd0;
         bytes_left <= '0;
         word_addr  <= '0;
      end else if (job_start) begin
         pack_word  <= '0;
         lane_idx   <= 2'd0;
         bytes_left <= num_bytes;
         word_addr  <= base_addr & ~ADDR_W'(3);
      end else if (accept) begin
         bytes_left <= bytes_left - LEN_W'(1);
         if (push) begin
            pack_word <= '0;
            lane_idx  <= 2'd0;
            word_addr <= word_addr + ADDR_W'(4);
         end else begin
            pack_word <= push_data;
            lane_idx  <= lane_idx + 2'd1;
         end
      end
   end

   // Word FIFO: address, data and strobe stored together per entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_count <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_addr[i] <= '0;
            mem_data[i] <= '0;
            mem_strb[i] <= '0;
         end
      end else begin
         fifo_count <= count_nxt;
         if (push) begin
            mem_addr[wr_ptr] <= word_addr;
            mem_data[wr_ptr] <= push_data;
            mem_strb[wr_ptr] <= push_strb;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

`ifdef PACKER_PERF_CNT_EN
   // Count cycles the GLB holds off a pending write; saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= 32'd0;
      else if (job_start)
         stall_cnt <= 32'd0;
      else if (wr_valid && !wr_ready && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppu_out_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_out_packer
// Purpose  : Self-checking bench for ppu_out_packer with a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_out_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] num_bytes;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        busy;
   logic        done;
   logic [31:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  jb [64];
   logic [31:0] exp_addr [$];
   logic [31:0] exp_data [$];
   logic [3:0]  exp_strb [$];

   ppu_out_packer dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .num_bytes(num_bytes), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .busy(busy), .done(done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_zero_outputs(input string pfx);
      check({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
      check({pfx, "_wr_valid"}, 32'(wr_valid), 32'd0);
      check({pfx, "_wr_addr"},  wr_addr,       32'd0);
      check({pfx, "_wr_data"},  wr_data,       32'd0);
      check({pfx, "_wr_strb"},  32'(wr_strb),  32'd0);
      check({pfx, "_busy"},     32'(busy),     32'd0);
      check({pfx, "_done"},     32'(done),     32'd0);
      check({pfx, "_stall"},    stall_cnt,     32'd0);
   endtask

   // Expected write sequence: one word per 4 bytes, little-endian, last word
   // zero-padded with strobes only for the bytes present.
   task automatic build_model(input logic [31:0] base, input int num);
      logic [31:0] aligned;
      logic [31:0] d;
      logic [3:0]  s;
      aligned = {base[31:2], 2'b00};
      exp_addr.delete(); exp_data.delete(); exp_strb.delete();
      for (int w = 0; w * 4 < num; w++) begin
         d = 32'd0; s = 4'd0;
         for (int k = 0; k < 4; k++) begin
            if (w * 4 + k < num) begin
               d = d | (32'(jb[w * 4 + k]) << (8 * k));
               s = s | 4'(1 << k);
            end
         end
         exp_addr.push_back(aligned + 32'(4 * w));
         exp_data.push_back(d);
         exp_strb.push_back(s);
      end
   endtask

   // rmode: 0 ready always, 1 random ready, 2 hold off 20 stall cycles then ready.
   task automatic run_job(input logic [31:0] base, input int num, input int rmode,
                          input bit vrand, input bit mid_start, input int abort_after);
      int idx = 0;
      int cyc = 0;
      int last_hs = -1;
      int holds = 0;
      bit seen_done = 1'b0;
      bit aborted = 1'b0;
      build_model(base, num);
      @(negedge clk);
      start = 1'b1; base_addr = base; num_bytes = 16'(num);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      while (!seen_done && !aborted && cyc < 2000) begin
         if (abort_after > 0 && idx == abort_after) begin
            in_valid = 1'b0;
            rst = 1'b1;
            #1;
            check_zero_outputs("abort");
            @(negedge clk);
            rst = 1'b0;
            aborted = 1'b1;
         end else begin
            in_valid = (idx < num) && (!vrand || ($urandom_range(0, 3) != 0));
            in_data  = in_valid ? jb[idx] : 8'($urandom);
            start    = mid_start && (cyc == 6);
            if (start) begin
               base_addr = 32'hDEAD_0000; num_bytes = 16'd3;
            end
            case (rmode)
               0: wr_ready = 1'b1;
               1: wr_ready = 1'($urandom_range(0, 1));
               default: begin
                  if (holds < 20) begin
                     wr_ready = 1'b0;
                     if (wr_valid) begin
                        holds++;
                        if (holds == 20) check("in_ready_block_bytes", 32'(idx), 32'd8);
                     end
                  end else
                     wr_ready = 1'b1;
               end
            endcase
            if (done) begin
               seen_done = 1'b1;
               if (num > 0) check("done_latency", 32'(cyc), 32'(last_hs + 1));
               else         check("done_zero_len", 32'(cyc <= 1), 32'd1);
               check("words_left", 32'(exp_addr.size()), 32'd0);
               check("busy_in_done", 32'(busy), 32'd1);
            end
            if (wr_valid) begin
               if (exp_addr.size() == 0)
                  check("spurious_write", 32'(wr_valid), 32'd0);
               else begin
                  check("wr_addr", wr_addr, exp_addr[0]);
                  check("wr_data", wr_data, exp_data[0]);
                  check("wr_strb", 32'(wr_strb), 32'(exp_strb[0]));
                  if (wr_ready) begin
                     void'(exp_addr.pop_front());
                     void'(exp_data.pop_front());
                     void'(exp_strb.pop_front());
                     last_hs = cyc;
                  end
               end
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (!aborted) begin
         check("job_completed", 32'(seen_done), 32'd1);
         check("done_one_cycle", 32'(done), 32'd0);
         check("idle_after_done", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; num_bytes = '0;
      in_valid = 1'b0; in_data = '0; wr_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // Aligned eight-byte job.
      for (int i = 0; i < 8; i++) jb[i] = 8'(i + 1);
      run_job(32'h0000_0100, 8, 0, 1'b0, 1'b0, 0);

      // Unaligned base and a one-byte trailing word.
      for (int i = 0; i < 5; i++) jb[i] = 8'(8'h11 + i);
      run_job(32'h0000_0203, 5, 0, 1'b0, 1'b0, 0);

      // GLB backpressure with an ignored start pulse in the middle.
      for (int i = 0; i < 16; i++) jb[i] = 8'($urandom);
      run_job(32'h0000_4000, 16, 2, 1'b0, 1'b1, 0);
`ifdef PACKER_PERF_CNT_EN
      check("stall_cnt", stall_cnt, 32'd20);
`else
      check("stall_cnt_tied", stall_cnt, 32'd0);
`endif

      // Zero-length job never writes.
      run_job(32'h0000_0800, 0, 0, 1'b0, 1'b0, 0);

      // Reset mid-job, then a clean job afterwards.
      for (int i = 0; i < 12; i++) jb[i] = 8'($urandom);
      run_job(32'h0000_1000, 12, 0, 1'b0, 1'b0, 6);
      for (int i = 0; i < 4; i++) jb[i] = 8'(8'hA0 + i);
      run_job(32'h0000_2000, 4, 0, 1'b0, 1'b0, 0);

      // Randomized jobs, including addresses that wrap past the top.
      for (int j = 0; j < 12; j++) begin
         logic [31:0] b;
         int n;
         b = (j % 3 == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
         n = $urandom_range(1, 23);
         for (int i = 0; i < n; i++) jb[i] = 8'($urandom);
         run_job(b, n, 1, 1'b1, 1'b0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
